// File: rtl/disp_pkg.sv
// disp_pkg: state encoding and frame constants shared by the display fetch path
package disp_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FRST,
        S_WAIT_ROOM,
        S_ADDR,
        S_DATA
    } state_t;
    localparam int BEAT_BYTES      = 8;
    localparam int DEF_BURST_LEN   = 16;
    localparam int DEF_FRAME_BEATS = 153600;
    localparam int DEF_RST_CYC     = 8;
    function automatic logic [31:0] burst_bytes(input int blen);
        return 32'(blen * BEAT_BYTES);
    endfunction
endpackage

// File: rtl/disp_fetch_addr_gen.sv
// disp_fetch_addr_gen: burst address register and frame beat counter
//   i_clk, i_rst   clock, async active-high reset
//   i_load/i_base  restart the frame: address <= base, counter <= 0
//   i_addr_inc     advance the address by one burst
//   i_beat         count one returned beat
//   o_addr         current burst address
//   o_last         the next counted beat is the last beat of the frame
module disp_fetch_addr_gen
    import disp_pkg::*;
#(
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int FRAME_BEATS = DEF_FRAME_BEATS
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_base,
    input  logic        i_addr_inc,
    input  logic        i_beat,
    output logic [31:0] o_addr,
    output logic        o_last
);
    localparam int CW = $clog2(FRAME_BEATS + 1);
    logic [31:0]   r_addr;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr <= '0;
            r_cnt  <= '0;
        end else begin
            r_addr <= i_load ? i_base : i_addr_inc ? r_addr + burst_bytes(BURST_LEN) : r_addr;
            r_cnt  <= i_load ? '0 : i_beat ? r_cnt + CW'(1) : r_cnt;
        end
    end
    assign o_addr = r_addr;
    assign o_last = r_cnt == CW'(FRAME_BEATS - 1);
endmodule

// File: rtl/disp_fetch_ctrl.sv
// disp_fetch_ctrl: frame fetch controller, AXI read bursts into the display line buffer
//   ACLK, ARST                      clock, async active-high reset
//   DISPON, VSTART, DISPADDR        display enable, frame-start pulse, frame base address
//   ARADDR/ARLEN/ARVALID/ARREADY    AXI read address channel
//   RDATA/RVALID/RLAST/RREADY       AXI read data channel
//   FIFORST, FIFOIN, FIFOWR         line buffer reset and write port
//   BUF_WREADY, BUF_OVER, BUF_UNDER line buffer room flag and error pulses
//   BUSY, FRAME_DONE, ERR           status
module disp_fetch_ctrl
    import disp_pkg::*;
#(
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int FRAME_BEATS = DEF_FRAME_BEATS,
    parameter int RST_CYC     = DEF_RST_CYC
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic        DISPON,
    input  logic        VSTART,
    input  logic [31:0] DISPADDR,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [63:0] RDATA,
    input  logic        RVALID,
    input  logic        RLAST,
    output logic        RREADY,
    output logic        FIFORST,
    output logic [63:0] FIFOIN,
    output logic        FIFOWR,
    input  logic        BUF_WREADY,
    input  logic        BUF_OVER,
    input  logic        BUF_UNDER,
    output logic        BUSY,
    output logic        FRAME_DONE,
    output logic        ERR
);
    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    state_t        r_state, w_next;
    logic [RW-1:0] r_rcnt;
    logic          r_pend;
    logic [31:0]   r_paddr;
    logic [63:0]   r_data;
    logic          r_wr, r_done, r_err;
    logic          w_load, w_addr_inc, w_beat, w_rdone, w_last, w_rst_done, w_vs;
    logic [31:0]   w_base, w_addr;

    assign w_vs       = VSTART & DISPON;
    assign w_beat     = (r_state == S_DATA) & RVALID;
    assign w_rdone    = w_beat & RLAST;
    assign w_addr_inc = (r_state == S_ADDR) & ARREADY;
    assign w_rst_done = r_rcnt == RW'(RST_CYC - 1);

    disp_fetch_addr_gen #(
        .BURST_LEN  (BURST_LEN),
        .FRAME_BEATS(FRAME_BEATS)
    ) u_addr (
        .i_clk     (ACLK),
        .i_rst     (ARST),
        .i_load    (w_load),
        .i_base    (w_base),
        .i_addr_inc(w_addr_inc),
        .i_beat    (w_beat),
        .o_addr    (w_addr),
        .o_last    (w_last)
    );

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    // A restart deferred from DATA uses the address captured with its VSTART,
    // unless a fresh VSTART arrives on the RLAST beat itself.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_base = DISPADDR;
        case (r_state)
            S_IDLE: if (w_vs) begin
                w_next = S_FRST;
                w_load = 1'b1;
            end
            S_FRST: if (w_rst_done) w_next = S_WAIT_ROOM;
            S_WAIT_ROOM: if (!DISPON) w_next = S_IDLE;
                else if (VSTART) begin
                    w_next = S_FRST;
                    w_load = 1'b1;
                end else if (BUF_WREADY) w_next = S_ADDR;
            S_ADDR: if (ARREADY) w_next = S_DATA;
                else if (w_vs) begin
                    w_next = S_FRST;
                    w_load = 1'b1;
                end
            S_DATA: if (w_rdone) begin
                if ((r_pend | VSTART) & DISPON) begin
                    w_next = S_FRST;
                    w_load = 1'b1;
                    w_base = VSTART ? DISPADDR : r_paddr;
                end else w_next = (!DISPON || w_last) ? S_IDLE : S_WAIT_ROOM;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) r_rcnt <= '0;
        else r_rcnt <= (r_state == S_FRST && !w_rst_done) ? r_rcnt + RW'(1) : '0;
    end

    // VSTART seen once a burst is committed is held until that burst drains.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            r_pend  <= 1'b0;
            r_paddr <= '0;
        end else if (w_rdone) r_pend <= 1'b0;
        else if (VSTART && (r_state == S_DATA || w_addr_inc)) begin
            r_pend  <= 1'b1;
            r_paddr <= DISPADDR;
        end
    end

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            r_data <= '0;
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_data <= w_beat ? RDATA : r_data;
            r_wr   <= w_beat;
            r_done <= w_beat & w_last;
            r_err  <= (w_load ? 1'b0 : r_err) | BUF_OVER | BUF_UNDER;
        end
    end

    assign ARADDR     = w_addr;
    assign ARLEN      = 8'(BURST_LEN - 1);
    assign ARVALID    = r_state == S_ADDR;
    assign RREADY     = r_state == S_DATA;
    assign FIFORST    = r_state == S_FRST;
    assign FIFOIN     = r_data;
    assign FIFOWR     = r_wr;
    assign BUSY       = r_state != S_IDLE;
    assign FRAME_DONE = r_done;
    assign ERR        = r_err;
endmodule
